// File: rtl/cache_ahb_pkg.sv
// Shared AHB-Lite encodings and the fill-controller state type.
package cache_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_WORD    = 3'h2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_ERR
  } fill_state_e;

  // Fixed-length burst code for a line of line_words words.
  function automatic logic [2:0] hburst_enc(input int line_words, input logic wrap);
    logic [2:0] enc;
    case (line_words)
      8:       enc = wrap ? HBURST_WRAP8  : HBURST_INCR8;
      16:      enc = wrap ? HBURST_WRAP16 : HBURST_INCR16;
      default: enc = wrap ? HBURST_WRAP4  : HBURST_INCR4;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/cache_burst_addr_gen.sv
// Beat address generator: loads the burst start address, steps the low
// line-index bits modulo the line size, and flags the final address phase.
module cache_burst_addr_gen
  import cache_ahb_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int LINE_WORDS = 4,
  parameter int WRAP_BURST = 1
) (
  input  logic              i_hclk,
  input  logic              i_hnreset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat
);

  localparam int IDX_W = $clog2(LINE_WORDS);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_load;
  logic [ADDR_W-1:0] addr_step;
  logic [IDX_W-1:0]  beat_reg;
  logic [IDX_W-1:0]  low_inc;

  // Low bits roll over inside the line, so neither mode ever leaves it.
  assign low_inc = addr_reg[IDX_W-1:0] + IDX_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_bit
      if (gi < IDX_W) begin : g_low
        assign addr_step[gi] = low_inc[gi];
        // INCR bursts start at the line base; WRAP bursts at the missed word.
        if (WRAP_BURST != 0) begin : g_wrap
          assign addr_load[gi] = start_addr[gi];
        end else begin : g_incr
          assign addr_load[gi] = 1'b0;
        end
      end else begin : g_high
        assign addr_step[gi] = addr_reg[gi];
        assign addr_load[gi] = start_addr[gi];
      end
    end
  endgenerate

  // Address and beat counter: load on request acceptance, step on each accepted address phase.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      addr_reg <= '0;
      beat_reg <= '0;
    end else if (load) begin
      addr_reg <= addr_load;
      beat_reg <= '0;
    end else if (step) begin
      addr_reg <= addr_step;
      beat_reg <= beat_reg + IDX_W'(1);
    end
  end

  assign addr      = addr_reg;
  assign last_beat = (beat_reg == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_ahb_fill_ctrl.sv
// AHB-Lite read master that refills one cache line per miss as a single
// fixed-length WRAP or INCR burst and streams the words back to the cache.
module cache_ahb_fill_ctrl
  import cache_ahb_pkg::*;
#(
  parameter int         ADDR_W     = 30,
  parameter int         LINE_WORDS = 4,
  parameter int         WRAP_BURST = 1,
  parameter logic [3:0] HPROT      = 4'h1
) (
  input  logic                          i_hclk,
  input  logic                          i_hnreset,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic                          o_ready,
  output logic [31:0]                   o_rdata,
  output logic                          o_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] o_rword,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_hsel,
  output logic [31:0]                   o_haddr,
  output logic                          o_hwrite,
  output logic [2:0]                    o_hsize,
  output logic [2:0]                    o_hburst,
  output logic [3:0]                    o_hprot,
  output logic [1:0]                    o_htrans,
  output logic [3:0]                    o_hmaster,
  output logic                          o_hready,
  output logic [31:0]                   o_hwdata,
  input  logic                          i_hready,
  input  logic                          i_hresp,
  input  logic [31:0]                   i_hrdata
);

  localparam int IDX_W = $clog2(LINE_WORDS);

  fill_state_e       state_reg;
  fill_state_e       state_next;
  logic              load;
  logic              step;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [IDX_W-1:0]  dword_reg;

  cache_burst_addr_gen #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .WRAP_BURST (WRAP_BURST)
  ) u_addr_gen (
    .i_hclk     (i_hclk),
    .i_hnreset  (i_hnreset),
    .load       (load),
    .step       (step),
    .start_addr (i_addr),
    .addr       (beat_addr),
    .last_beat  (last_beat)
  );

  // State register.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  // Line index of the beat now in its data phase (captured as its address phase is accepted).
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset)  dword_reg <= '0;
    else if (step)   dword_reg <= beat_addr[IDX_W-1:0];
  end

  // Next-state and bus/cache-side strobes. An ERROR seen on its first (hready=0)
  // cycle moves to ERR so the remaining beats are cancelled with IDLE.
  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_htrans   = HTRANS_IDLE;
    o_rvalid   = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_req) begin
          load       = 1'b1;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        o_htrans = HTRANS_NONSEQ;
        if (i_hready) begin
          step       = 1'b1;
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        o_htrans = HTRANS_SEQ;
        if (i_hready && !i_hresp) begin
          o_rvalid = 1'b1;
          step     = 1'b1;
          if (last_beat) state_next = ST_LAST;
        end else if (i_hready) begin
          // Error response already in its second cycle: finish at once.
          o_done     = 1'b1;
          o_err      = 1'b1;
          state_next = ST_IDLE;
        end else if (i_hresp) begin
          state_next = ST_ERR;
        end
      end
      ST_LAST: begin
        if (i_hready) begin
          o_rvalid   = !i_hresp;
          o_done     = 1'b1;
          o_err      = i_hresp;
          state_next = ST_IDLE;
        end else if (i_hresp) begin
          state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        if (i_hready) begin
          o_done     = 1'b1;
          o_err      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_rdata   = o_rvalid ? i_hrdata : 32'h0;
  assign o_rword   = dword_reg;
  assign o_hsel    = (o_htrans != HTRANS_IDLE);
  assign o_haddr   = {beat_addr, 2'b00};
  assign o_hwrite  = 1'b0;
  assign o_hsize   = HSIZE_WORD;
  assign o_hburst  = hburst_enc(LINE_WORDS, WRAP_BURST != 0);
  assign o_hprot   = HPROT;
  assign o_hmaster = 4'h0;
  assign o_hready  = i_hready;
  assign o_hwdata  = 32'h0;

endmodule

// File: tb/tb_cache_ahb_fill_ctrl.sv
// Table-driven bench for the line-fill controller: a WRAP4 instance and an
// INCR8 instance share one stimulus; each vector row selects which one to check.
module tb_cache_ahb_fill_ctrl;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req = 1'b0;
  logic [29:0] addr = '0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  logic        r4_ready, r4_rvalid, r4_done, r4_err, r4_hsel, r4_hwrite, r4_hready;
  logic [31:0] r4_rdata, r4_haddr, r4_hwdata;
  logic [1:0]  r4_rword, r4_htrans;
  logic [2:0]  r4_hsize, r4_hburst;
  logic [3:0]  r4_hprot, r4_hmaster;

  logic        r8_ready, r8_rvalid, r8_done, r8_err, r8_hsel, r8_hwrite, r8_hready;
  logic [31:0] r8_rdata, r8_haddr, r8_hwdata;
  logic [2:0]  r8_rword;
  logic [1:0]  r8_htrans;
  logic [2:0]  r8_hsize, r8_hburst;
  logic [3:0]  r8_hprot, r8_hmaster;

  cache_ahb_fill_ctrl #(.ADDR_W(30), .LINE_WORDS(4), .WRAP_BURST(1), .HPROT(4'h1)) dut4 (
    .i_hclk(clk), .i_hnreset(nrst), .i_req(req), .i_addr(addr),
    .o_ready(r4_ready), .o_rdata(r4_rdata), .o_rvalid(r4_rvalid), .o_rword(r4_rword),
    .o_done(r4_done), .o_err(r4_err), .o_hsel(r4_hsel), .o_haddr(r4_haddr),
    .o_hwrite(r4_hwrite), .o_hsize(r4_hsize), .o_hburst(r4_hburst), .o_hprot(r4_hprot),
    .o_htrans(r4_htrans), .o_hmaster(r4_hmaster), .o_hready(r4_hready), .o_hwdata(r4_hwdata),
    .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata)
  );

  cache_ahb_fill_ctrl #(.ADDR_W(30), .LINE_WORDS(8), .WRAP_BURST(0), .HPROT(4'h1)) dut8 (
    .i_hclk(clk), .i_hnreset(nrst), .i_req(req), .i_addr(addr),
    .o_ready(r8_ready), .o_rdata(r8_rdata), .o_rvalid(r8_rvalid), .o_rword(r8_rword),
    .o_done(r8_done), .o_err(r8_err), .o_hsel(r8_hsel), .o_haddr(r8_haddr),
    .o_hwrite(r8_hwrite), .o_hsize(r8_hsize), .o_hburst(r8_hburst), .o_hprot(r8_hprot),
    .o_htrans(r8_htrans), .o_hmaster(r8_hmaster), .o_hready(r8_hready), .o_hwdata(r8_hwdata),
    .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata)
  );

  // Outputs of the instance the current vector targets.
  logic        m_ready, m_rvalid, m_done, m_err, m_hsel;
  logic [31:0] m_rdata, m_haddr;
  logic [1:0]  m_htrans;
  logic [3:0]  m_rword;
  always_comb begin
    m_ready  = sel ? r8_ready  : r4_ready;
    m_rvalid = sel ? r8_rvalid : r4_rvalid;
    m_done   = sel ? r8_done   : r4_done;
    m_err    = sel ? r8_err    : r4_err;
    m_hsel   = sel ? r8_hsel   : r4_hsel;
    m_rdata  = sel ? r8_rdata  : r4_rdata;
    m_haddr  = sel ? r8_haddr  : r4_haddr;
    m_htrans = sel ? r8_htrans : r4_htrans;
    m_rword  = sel ? {1'b0, r8_rword} : {2'b00, r4_rword};
  end

  typedef struct {
    string       name;
    bit          rst;
    bit          sel;
    bit          req;
    logic [29:0] addr;
    bit          hready;
    bit          hresp;
    logic [31:0] hrdata;
    bit          ready;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    bit          rvalid;
    logic [3:0]  rword;
    bit          done;
    bit          err;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   wrap_lo, wrap_hi;

  function automatic void add(string n, bit rst, bit s, bit rq, logic [29:0] a, bit hr, bit hp,
                              logic [31:0] d, bit rdy, logic [1:0] tr, logic [31:0] ha, bit rv,
                              logic [3:0] rw, bit dn, bit er);
    vec_t v;
    v.name = n; v.rst = rst; v.sel = s; v.req = rq; v.addr = a; v.hready = hr; v.hresp = hp;
    v.hrdata = d; v.ready = rdy; v.htrans = tr; v.haddr = ha; v.rvalid = rv; v.rword = rw;
    v.done = dn; v.err = er;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s act=%0h", n, act);
    end else begin
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; req = 1'b0; hready = 1'b1; hresp = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic check_reset(input string n);
    chk({n, " dut4"}, {r4_ready, r4_htrans, r4_hsel, r4_haddr, r4_rvalid, r4_rdata, r4_done, r4_err},
        {1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0});
    chk({n, " dut8"}, {r8_ready, r8_htrans, r8_hsel, r8_haddr, r8_rvalid, r8_rdata, r8_done, r8_err},
        {1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0});
  endtask

  task automatic run_row(input int i, input bit allow_rst);
    vec_t v;
    bit   act_ph;
    v = vecs[i];
    if (v.rst && allow_rst) do_reset();
    @(negedge clk);
    sel = v.sel; req = v.req; addr = v.addr; hready = v.hready; hresp = v.hresp; hrdata = v.hrdata;
    #1;
    act_ph = (v.htrans != ID);
    chk($sformatf("%s #%0d", v.name, i),
        {m_ready, m_htrans, m_hsel, act_ph ? m_haddr : 32'h0, m_rvalid, m_rdata,
         v.rvalid ? m_rword : 4'h0, m_done, m_err},
        {v.ready, v.htrans, act_ph, act_ph ? v.haddr : 32'h0, v.rvalid,
         v.rvalid ? v.hrdata : 32'h0, v.rvalid ? v.rword : 4'h0, v.done, v.err});
  endtask

  initial begin
    // WRAP4 from word 6: critical word 2 first.
    wrap_lo = vecs.size();
    add("wrap4", 1, 0, 1, 30'h100_0006, 1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);
    add("wrap4", 0, 0, 0, 30'h0,        1, 0, 32'h0,         0, NS, 32'h0400_0018, 0, 0, 0, 0);
    add("wrap4", 0, 0, 0, 30'h0,        1, 0, 32'hA000_0002, 0, SQ, 32'h0400_001C, 1, 2, 0, 0);
    add("wrap4", 0, 0, 0, 30'h0,        1, 0, 32'hA000_0003, 0, SQ, 32'h0400_0010, 1, 3, 0, 0);
    add("wrap4", 0, 0, 0, 30'h0,        1, 0, 32'hA000_0000, 0, SQ, 32'h0400_0014, 1, 0, 0, 0);
    add("wrap4", 0, 0, 0, 30'h0,        1, 0, 32'hA000_0001, 0, ID, 32'h0,         1, 1, 1, 0);
    add("wrap4", 0, 0, 0, 30'h0,        1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);
    wrap_hi = vecs.size();

    // INCR8 from word 5: starts at line base 0.
    add("incr8", 1, 1, 1, 30'h5, 1, 0, 32'h0, 1, ID, 32'h0, 0, 0, 0, 0);
    add("incr8", 0, 1, 0, 30'h0, 1, 0, 32'h0, 0, NS, 32'h0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      add("incr8", 0, 1, 0, 30'h0, 1, 0, 32'hB000_0000 + k, 0, SQ, 32'(4 * (k + 1)), 1, 4'(k), 0, 0);
    add("incr8", 0, 1, 0, 30'h0, 1, 0, 32'hB000_0007, 0, ID, 32'h0, 1, 7, 1, 0);
    add("incr8", 0, 1, 0, 30'h0, 1, 0, 32'h0,         1, ID, 32'h0, 0, 0, 0, 0);

    // One wait state on the beat-2 data phase.
    add("wait", 1, 0, 1, 30'h100_0006, 1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);
    add("wait", 0, 0, 0, 30'h0,        1, 0, 32'h0,         0, NS, 32'h0400_0018, 0, 0, 0, 0);
    add("wait", 0, 0, 0, 30'h0,        1, 0, 32'hC000_0002, 0, SQ, 32'h0400_001C, 1, 2, 0, 0);
    add("wait", 0, 0, 0, 30'h0,        1, 0, 32'hC000_0003, 0, SQ, 32'h0400_0010, 1, 3, 0, 0);
    add("wait", 0, 0, 0, 30'h0,        0, 0, 32'hDEAD_BEEF, 0, SQ, 32'h0400_0014, 0, 0, 0, 0);
    add("wait", 0, 0, 0, 30'h0,        1, 0, 32'hC000_0000, 0, SQ, 32'h0400_0014, 1, 0, 0, 0);
    add("wait", 0, 0, 0, 30'h0,        1, 0, 32'hC000_0001, 0, ID, 32'h0,         1, 1, 1, 0);
    add("wait", 0, 0, 0, 30'h0,        1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);

    // Two-cycle ERROR on beat 1.
    add("err", 1, 0, 1, 30'h100_0006, 1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);
    add("err", 0, 0, 0, 30'h0,        1, 0, 32'h0,         0, NS, 32'h0400_0018, 0, 0, 0, 0);
    add("err", 0, 0, 0, 30'h0,        1, 0, 32'hE000_0002, 0, SQ, 32'h0400_001C, 1, 2, 0, 0);
    add("err", 0, 0, 0, 30'h0,        0, 1, 32'hE000_0003, 0, SQ, 32'h0400_0010, 0, 0, 0, 0);
    add("err", 0, 0, 0, 30'h0,        1, 1, 32'hE000_0003, 0, ID, 32'h0,         0, 0, 1, 1);
    add("err", 0, 0, 0, 30'h0,        1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);

    // Requests while busy are ignored; exactly one burst.
    add("busy", 1, 0, 1, 30'h100_0006,  1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);
    add("busy", 0, 0, 1, 30'h3FF_FFF1,  1, 0, 32'h0,         0, NS, 32'h0400_0018, 0, 0, 0, 0);
    add("busy", 0, 0, 1, 30'h3FF_FFF1,  1, 0, 32'hF000_0002, 0, SQ, 32'h0400_001C, 1, 2, 0, 0);
    add("busy", 0, 0, 1, 30'h3FF_FFF1,  1, 0, 32'hF000_0003, 0, SQ, 32'h0400_0010, 1, 3, 0, 0);
    add("busy", 0, 0, 1, 30'h3FF_FFF1,  1, 0, 32'hF000_0000, 0, SQ, 32'h0400_0014, 1, 0, 0, 0);
    add("busy", 0, 0, 1, 30'h3FF_FFF1,  1, 0, 32'hF000_0001, 0, ID, 32'h0,         1, 1, 1, 0);
    add("busy", 0, 0, 0, 30'h0,         1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);
    add("busy", 0, 0, 0, 30'h0,         1, 0, 32'h0,         1, ID, 32'h0,         0, 0, 0, 0);

    // Reset state and constant outputs (hready=0 exercises the pass-through).
    hready = 1'b0;
    #1;
    check_reset("reset");
    chk("const4", {r4_hburst, r4_hsize, r4_hprot, r4_hwrite, r4_hmaster, r4_hwdata, r4_hready},
        {3'b010, 3'h2, 4'h1, 1'b0, 4'h0, 32'h0, 1'b0});
    chk("const8", {r8_hburst, r8_hsize, r8_hprot, r8_hwrite, r8_hmaster, r8_hwdata, r8_hready},
        {3'b101, 3'h2, 4'h1, 1'b0, 4'h0, 32'h0, 1'b0});
    hready = 1'b1;
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_row(i, 1'b1);

    // Asynchronous reset after beat 1, then a fresh fill must complete normally.
    do_reset();
    for (int i = wrap_lo; i < wrap_lo + 4; i++) run_row(i, 1'b0);
    #2 nrst = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    nrst = 1'b1;
    for (int i = wrap_lo; i < wrap_hi; i++) run_row(i, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
